// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared constants and types for the CRC-32 message framer
// Contents: CRC_W, default generator polynomial, INIT/XOROUT conditioning
// constants, the framer FSM state enum, the FIFO entry struct and a one-bit
// CRC step helper.
// Optional feature macro: CRC32_FRAMER_XOROUT_EN selects CRC-32/BZIP2
// conditioning (INIT = XOROUT = 0xFFFFFFFF); otherwise both are zero and the
// result is the raw remainder mod G.
package crc_pkg;

    localparam int CRC_W = 32;

    localparam logic [CRC_W-1:0] CRC_POLY_DEFAULT = 32'h04C11DB7;

`ifdef CRC32_FRAMER_XOROUT_EN
    localparam logic [CRC_W-1:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [CRC_W-1:0] CRC_XOROUT = 32'hFFFF_FFFF;
`else
    localparam logic [CRC_W-1:0] CRC_INIT   = 32'h0000_0000;
    localparam logic [CRC_W-1:0] CRC_XOROUT = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             last;
        logic [CRC_W-1:0] data;
    } fifo_entry_t;

    // One message bit folded into the remainder, MSB-first, non-reflected.
    function automatic logic [CRC_W-1:0] crc_step(
        input logic [CRC_W-1:0] crc,
        input logic             b,
        input logic [CRC_W-1:0] poly
    );
        logic fb;
        fb = crc[CRC_W-1] ^ b;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc_word_fifo.sv
// rtl/crc_word_fifo.sv - registered word FIFO holding {last, data} entries
// Ports:
//   clk_i, rst_i   clock (rising edge), asynchronous active-high reset (flushes)
//   wr_en_i        write request; ignored while full
//   wr_data_i      entry to write
//   full_o         DEPTH entries stored
//   rd_en_i        pop request; ignored while empty
//   rd_data_o      head entry (valid while !empty_o)
//   empty_o        no entries stored
module crc_word_fifo
    import crc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  fifo_entry_t wr_data_i,
    output logic        full_o,
    input  logic        rd_en_i,
    output fifo_entry_t rd_data_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/crc32_msg_framer.sv
// rtl/crc32_msg_framer.sv - buffers message words and returns one CRC-32 per message
// Ports:
//   clk_i, rst_i    clock (rising edge), asynchronous active-high reset
//   s_valid_i       input word valid
//   s_data_i        message word, bit 31 processed first
//   s_last_i        word closes its message
//   s_ready_o       input FIFO not full
//   crc_valid_o     crc_o holds a finished message CRC
//   crc_o           final CRC (zero when no result is pending)
//   crc_ready_i     consumer takes the CRC
//   busy_o          message in progress or result pending
// Optional feature macro: CRC32_FRAMER_XOROUT_EN (see crc_pkg).
module crc32_msg_framer
    import crc_pkg::*;
#(
    parameter int               FIFO_DEPTH = 4,
    parameter logic [CRC_W-1:0] POLY       = CRC_POLY_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    input  logic [CRC_W-1:0] s_data_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic             crc_valid_o,
    output logic [CRC_W-1:0] crc_o,
    input  logic             crc_ready_i,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(CRC_W);

    state_t           state_q;
    state_t           state_nx;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] shift_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    fifo_entry_t      wr_entry;
    fifo_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             load_first;

    assign wr_entry = {s_last_i, s_data_i};

    crc_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (s_valid_i),
        .wr_data_i (wr_entry),
        .full_o    (fifo_full),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_nx   = state_q;
        pop        = 1'b0;
        load_first = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load_first = 1'b1;
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                // Reloading on the final-bit edge keeps back-to-back words bubble-free.
                if (cnt_q == '0) begin
                    if (last_q) begin
                        state_nx = DONE;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = SHIFT;
                end
            end
            DONE: begin
                if (crc_ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (load_first) begin
                crc_q <= CRC_INIT;
            end else if (state_q == SHIFT) begin
                crc_q <= crc_step(crc_q, shift_q[CRC_W-1], POLY);
            end

            if (pop) begin
                shift_q <= head.data;
                last_q  <= head.last;
                cnt_q   <= CNT_W'(CRC_W - 1);
            end else if (state_q == SHIFT) begin
                shift_q <= {shift_q[CRC_W-2:0], 1'b0};
                cnt_q   <= cnt_q - 1'b1;
            end
        end
    end

    assign s_ready_o   = !fifo_full;
    assign crc_valid_o = (state_q == DONE);
    assign crc_o       = crc_valid_o ? (crc_q ^ CRC_XOROUT) : '0;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_crc32_msg_framer.sv
// tb/tb_crc32_msg_framer.sv - randomized self-checking bench for crc32_msg_framer
module tb_crc32_msg_framer;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] T_POLY = 32'h04C11DB7;
`ifdef CRC32_FRAMER_XOROUT_EN
    localparam logic [31:0] T_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] T_XOR  = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] T_INIT = 32'h0;
    localparam logic [31:0] T_XOR  = 32'h0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        s_valid_i = 1'b0;
    logic [31:0] s_data_i = '0;
    logic        s_last_i = 1'b0;
    logic        s_ready_o;
    logic        crc_valid_o;
    logic [31:0] crc_o;
    logic        crc_ready_i = 1'b0;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    crc32_msg_framer #(
        .FIFO_DEPTH (DEPTH),
        .POLY       (T_POLY)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .s_ready_o   (s_ready_o),
        .crc_valid_o (crc_valid_o),
        .crc_o       (crc_o),
        .crc_ready_i (crc_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    // Reference: polynomial long division of (M(x)*x^32 + INIT*x^n) by G.
    function automatic logic [31:0] golden(input logic [31:0] w[$]);
        bit          b[$];
        int          n;
        logic [31:0] r;
        foreach (w[i]) for (int k = 31; k >= 0; k--) b.push_back(w[i][k]);
        n = b.size();
        for (int i = 0; i < 32; i++) b.push_back(1'b0);
        for (int i = 0; i < 32; i++) b[i] = b[i] ^ T_INIT[31-i];
        for (int i = 0; i < n; i++) begin
            if (b[i]) begin
                b[i] = 1'b0;
                for (int j = 0; j < 32; j++) b[i+1+j] = b[i+1+j] ^ T_POLY[31-j];
            end
        end
        for (int j = 0; j < 32; j++) r[31-j] = b[n+j];
        return r ^ T_XOR;
    endfunction

    task automatic push(input logic [31:0] d, input logic l, output int k);
        int w;
        @(negedge clk_i);
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        w = 0;
        while (!s_ready_o && w < 1000) begin
            @(negedge clk_i);
            w++;
        end
        if (!s_ready_o) begin
            total++; bad++;
            $display("FAIL push_timeout: s_ready_o=%0b required 1", s_ready_o);
        end
        @(posedge clk_i);
        #1;
        k = cyc;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    // Pushes a whole message with crc_ready_i=1; returns the CRC and the
    // number of edges from the first accept to crc_valid_o (-1 on timeout).
    task automatic run_msg(input logic [31:0] w[$], output logic [31:0] crc, output int lat);
        int k0, k;
        bit seen;
        crc_ready_i = 1'b1;
        k0 = 0;
        foreach (w[i]) begin
            push(w[i], (i == w.size() - 1), k);
            if (i == 0) k0 = k;
        end
        seen = 0; lat = -1; crc = 'x;
        for (int i = 0; i < 600 && !seen; i++) begin
            if (crc_valid_o) begin
                seen = 1;
                lat  = cyc - k0;
                crc  = crc_o;
            end else begin
                @(posedge clk_i);
                #1;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        if (s_ready_o !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %0b want 1", s_ready_o); end
        total++;
        if (crc_valid_o !== 1'b0) begin bad++; $display("FAIL reset_crc_valid: got %0b want 0", crc_valid_o); end
        total++;
        if (crc_o !== 32'h0) begin bad++; $display("FAIL reset_crc_o: got %h want 00000000", crc_o); end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        total++;
    endtask

`ifndef CRC32_FRAMER_XOROUT_EN
    task automatic test_single_word;
        logic [31:0] w[$];
        logic [31:0] c;
        int lat;
        w = '{32'h0000_0001};
        run_msg(w, c, lat);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL single_latency: got %0d want 33", lat); end
        total++;
        if (c !== 32'h04C11DB7) begin bad++; $display("FAIL single_crc: got %h want 04c11db7", c); end
        total++;
        if (busy_o !== 1'b0 || crc_valid_o !== 1'b0) begin
            bad++; $display("FAIL single_return_idle: busy=%0b valid=%0b want 0 0", busy_o, crc_valid_o);
        end
    endtask

    task automatic test_two_words;
        logic [31:0] w[$];
        logic [31:0] c;
        int lat;
        w = '{32'h0000_0000, 32'h0000_0001};
        run_msg(w, c, lat);
        total++;
        if (lat !== 65) begin bad++; $display("FAIL two_latency: got %0d want 65", lat); end
        total++;
        if (c !== 32'h04C11DB7) begin bad++; $display("FAIL two_crc: got %h want 04c11db7", c); end
    endtask
`else
    task automatic test_xorout;
        logic [31:0] w[$];
        logic [31:0] c1, c0;
        int lat;
        w = '{32'h0000_0001};
        run_msg(w, c1, lat);
        total++;
        if (c1 !== golden(w)) begin bad++; $display("FAIL xor_crc1: got %h want %h", c1, golden(w)); end
        w = '{32'h0000_0000};
        run_msg(w, c0, lat);
        total++;
        if (c0 !== golden(w)) begin bad++; $display("FAIL xor_crc0: got %h want %h", c0, golden(w)); end
        total++;
        if ((c1 ^ c0) !== 32'h04C11DB7) begin bad++; $display("FAIL xor_diff: got %h want 04c11db7", c1 ^ c0); end
    endtask
`endif

    task automatic test_random_stream;
        logic [31:0] exp[$];
        int got;
        got = 0;
        fork
            begin
                int k;
                for (int m = 0; m < 4; m++) begin
                    logic [31:0] w[$];
                    int len;
                    len = $urandom_range(1, 6);
                    w = {};
                    for (int i = 0; i < len; i++) w.push_back($urandom());
                    exp.push_back(golden(w));
                    foreach (w[i]) push(w[i], (i == len - 1), k);
                end
            end
            begin
                int t;
                t = 0;
                while (got < 4 && t < 5000) begin
                    @(negedge clk_i);
                    crc_ready_i = 1'($urandom_range(0, 1));
                    if (crc_valid_o && crc_ready_i) begin
                        logic [31:0] e;
                        e = exp.pop_front();
                        total++;
                        if (crc_o !== e) begin bad++; $display("FAIL random_crc%0d: got %h want %h", got, crc_o, e); end
                        got++;
                    end
                    t++;
                end
            end
        join
        total++;
        if (got != 4) begin bad++; $display("FAIL random_count: got %0d results want 4", got); end
        @(posedge clk_i);
        #1;
        crc_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] w[$];
        logic [31:0] c;
        int k0, k, lat;
        crc_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push($urandom(), (i == 2), k);
            if (i == 0) k0 = k;
        end
        while (cyc < k0 + 45) begin
            @(posedge clk_i);
            #1;
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0b want 0", busy_o); end
        total++;
        if (crc_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", crc_valid_o); end
        total++;
        if (crc_o !== 32'h0) begin bad++; $display("FAIL midrst_crc_o: got %h want 00000000", crc_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        total++;
        if (busy_o !== 1'b0 || s_ready_o !== 1'b1) begin
            bad++; $display("FAIL midrst_flushed: busy=%0b ready=%0b want 0 1", busy_o, s_ready_o);
        end
        w = '{$urandom(), $urandom()};
        run_msg(w, c, lat);
        total++;
        if (c !== golden(w)) begin bad++; $display("FAIL midrst_fresh_crc: got %h want %h", c, golden(w)); end
    endtask

    task automatic test_stall_done;
        logic [31:0] wa[$];
        logic [31:0] wb[$];
        logic [31:0] held, c;
        bit seen, stable;
        int k;
        crc_ready_i = 1'b0;
        wa = '{$urandom()};
        push(wa[0], 1'b1, k);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk_i);
            #1;
            seen = crc_valid_o;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL stall_first_valid: got 0 want 1"); end
        held = crc_o;
        for (int i = 0; i < DEPTH; i++) begin
            wb.push_back($urandom());
            push(wb[i], (i == DEPTH - 1), k);
            total++;
            if (s_ready_o !== (i < DEPTH - 1)) begin
                bad++; $display("FAIL stall_ready_after_%0d: got %0b want %0b", i + 1, s_ready_o, (i < DEPTH - 1));
            end
        end
        stable = 1;
        for (int i = 0; i < 96; i++) begin
            @(posedge clk_i);
            #1;
            if (crc_o !== held || crc_valid_o !== 1'b1 || s_ready_o !== 1'b0) stable = 0;
        end
        total++;
        if (!stable) begin bad++; $display("FAIL stall_hold: crc=%h valid=%0b ready=%0b want %h 1 0", crc_o, crc_valid_o, s_ready_o, held); end
        total++;
        if (held !== golden(wa)) begin bad++; $display("FAIL stall_crc_a: got %h want %h", held, golden(wa)); end
        @(negedge clk_i);
        crc_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        seen = 0; c = 'x;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk_i);
            #1;
            if (crc_valid_o) begin seen = 1; c = crc_o; end
        end
        total++;
        if (c !== golden(wb)) begin bad++; $display("FAIL stall_crc_b: got %h want %h", c, golden(wb)); end
        @(posedge clk_i);
        #1;
        crc_ready_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        test_reset();
`ifndef CRC32_FRAMER_XOROUT_EN
        test_single_word();
        test_two_words();
`else
        test_xorout();
`endif
        test_random_stream();
        test_reset_mid();
        test_stall_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
